sort4_ctrl: RTL and testbench

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_ctrl.sv | 152 +++++++++++++++
 tb/tb_sort4_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads four elements, bubble-sorts them ascending with one shared
// magnitude comparator, then drains them smallest-first over a valid/ready port.
// Optional build macro SORT_EARLY_EXIT_EN: leave SORT after the first pass
// that makes no swap (3, 6 or 9 cycles) instead of always running 9 cycles.

module sort4_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         g,
  output logic         l,
  output logic         e
);
  // Unsigned magnitude compare of a against b
  always_comb begin
    g = (a > b);
    l = (a < b);
    e = (a == b);
  end
endmodule

module sort4_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t                 state, state_nx;
  logic [3:0][WIDTH-1:0]  sbuf;
  logic [1:0]             wcnt, rcnt, idx, pass;
  logic                   swapped;
  logic [1:0]             idx_p1;
  logic [WIDTH-1:0]       cmp_a, cmp_b;
  logic                   cmp_g, cmp_l, cmp_e;
  logic                   load_done, pass_end, sort_done, drain_done;

  // idx never reaches 3 in SORT, so idx+1 stays inside the buffer
  assign idx_p1 = idx + 2'd1;
  assign cmp_a  = sbuf[idx];
  assign cmp_b  = sbuf[idx_p1];

  sort4_cmp #(.W(WIDTH)) u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .g (cmp_g),
    .l (cmp_l),
    .e (cmp_e)
  );

  // Phase-completion terms shared by the FSM and the datapath
  always_comb begin
    load_done  = in_valid && (wcnt == 2'd3);
    pass_end   = (idx == 2'd2);
`ifdef SORT_EARLY_EXIT_EN
    sort_done  = pass_end && ((pass == 2'd2) || (!swapped && !cmp_g));
`else
    sort_done  = pass_end && (pass == 2'd2);
`endif
    drain_done = out_ready && (rcnt == 2'd3);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (load_done)  state_nx = S_SORT;
      S_SORT:  if (sort_done)  state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_LOAD;
      default:                 state_nx = S_LOAD;
    endcase
  end

  // Moore outputs; out_data is forced to zero outside DRAIN
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD:  in_ready = 1'b1;
      S_SORT:  busy     = 1'b1;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = sbuf[rcnt];
        out_last  = (rcnt == 2'd3);
      end
      default: ;
    endcase
  end

  // Buffer, counters and compare-step bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf    <= '0;
      wcnt    <= 2'd0;
      rcnt    <= 2'd0;
      idx     <= 2'd0;
      pass    <= 2'd0;
      swapped <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (in_valid) begin
          sbuf[wcnt] <= in_data;
          wcnt       <= wcnt + 2'd1;
          if (wcnt == 2'd3) begin
            idx     <= 2'd0;
            pass    <= 2'd0;
            swapped <= 1'b0;
          end
        end
        S_SORT: begin
          // Only strictly greater swaps, so equal keys keep their order
          if (cmp_g) begin
            sbuf[idx]    <= cmp_b;
            sbuf[idx_p1] <= cmp_a;
          end
          if (pass_end) begin
            idx     <= 2'd0;
            pass    <= pass + 2'd1;
            swapped <= 1'b0;
          end else begin
            idx     <= idx_p1;
            swapped <= swapped | cmp_g;
          end
        end
        S_DRAIN: if (out_ready) begin
          rcnt <= rcnt + 2'd1;
          if (rcnt == 2'd3) wcnt <= 2'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: directed frames for sort4_ctrl, checked every cycle against a
// queue-based model plus literal expectations per frame.

module tb_sort4_ctrl;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] in_data, out_data;
  logic       in_ready, out_valid, out_last, busy;

  int n_cmp = 0;
  int n_bad = 0;

  sort4_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // phase 0 = collecting, 1 = sorting (cycles left), 2 = emitting sorted queue
  int ph = 0;
  int sleft = 0;
  bit armed = 0;
  int mload[$];
  int mout[$];
  int got[$];
  int glast[$];
  int busy_cnt = 0;
  int w[4];

  // Number of SORT cycles the frame in w[] should take
  function automatic int sort_len();
    int t[4];
    int tmp;
    bit sw;
    for (int i = 0; i < 4; i++) t[i] = w[i];
`ifdef SORT_EARLY_EXIT_EN
    for (int p = 0; p < 3; p++) begin
      sw = 0;
      for (int i = 0; i < 3; i++)
        if (t[i] > t[i+1]) begin tmp = t[i]; t[i] = t[i+1]; t[i+1] = tmp; sw = 1; end
      if (!sw) return 3 * (p + 1);
    end
    return 9;
`else
    sw = 0;
    tmp = t[0];
    return 9;
`endif
  endfunction

  // Outputs are compared mid-cycle, then the model absorbs the inputs that the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",  in_ready,  ph == 0);
      chk("out_valid", out_valid, ph == 2);
      chk("busy",      busy,      ph == 1);
      chk("out_data",  out_data,  (ph == 2) ? mout[0] : 0);
      chk("out_last",  out_last,  (ph == 2) && (mout.size() == 1));
      if (busy) busy_cnt++;
    end
    if (rst) begin
      ph = 0; mload.delete(); mout.delete(); armed = 1;
    end else if (armed) begin
      case (ph)
        0: if (in_valid) begin
          mload.push_back(int'(in_data));
          if (mload.size() == 4) begin
            for (int i = 0; i < 4; i++) w[i] = mload[i];
            sleft = sort_len();
            // plain insertion sort gives the required ascending order
            for (int i = 1; i < 4; i++)
              for (int j = i; j > 0 && w[j-1] > w[j]; j--) begin
                int x; x = w[j]; w[j] = w[j-1]; w[j-1] = x;
              end
            mout.delete();
            for (int i = 0; i < 4; i++) mout.push_back(w[i]);
            mload.delete();
            ph = 1;
          end
        end
        1: begin
          sleft--;
          if (sleft == 0) ph = 2;
        end
        default: if (out_ready) begin
          got.push_back(int'(out_data));
          glast.push_back(int'(out_last));
          void'(mout.pop_front());
          if (mout.size() == 0) ph = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load4(input int a0, input int a1, input int a2, input int a3);
    int v[4];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = v[i][3:0]; step();
    end
    in_valid = 1'b0;
  endtask

  task automatic frame(input string tag,
                       input int a0, input int a1, input int a2, input int a3,
                       input int e0, input int e1, input int e2, input int e3,
                       input int bexp, input bit hold, input bit pulse);
    int e[4];
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    got.delete(); glast.delete(); busy_cnt = 0;
    out_ready = !hold;
    load4(a0, a1, a2, a3);
    if (pulse) begin
      in_valid = 1'b1; in_data = 4'hF; step();
      chk({tag, "_pulse_in_ready"}, in_ready, 0);
      step();
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk({tag, "_drain_seen"}, out_valid, 1);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_data"}, out_data, e[0]);
        chk({tag, "_hold_last"}, out_last, 0);
        step();
      end
      out_ready = 1'b1;
    end
    n = 0;
    while (got.size() < 4 && n < 20) begin step(); n++; end
    step();
    chk({tag, "_count"}, got.size(), 4);
    if (got.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_data"}, got[i], e[i]);
        chk({tag, "_last"}, glast[i], (i == 3) ? 1 : 0);
      end
    chk({tag, "_busy_cycles"}, busy_cnt, bexp);
    chk({tag, "_back_to_load"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    step();

    frame("f9371",  9, 3, 7, 1,   1, 3, 7, 9,   9, 0, 0);
`ifdef SORT_EARLY_EXIT_EN
    frame("f1234",  1, 2, 3, 4,   1, 2, 3, 4,   3, 0, 0);
`else
    frame("f1234",  1, 2, 3, 4,   1, 2, 3, 4,   9, 0, 0);
`endif
    frame("f5505",  5, 5, 0, 5,   0, 5, 5, 5,   9, 0, 0);
    frame("fF0F0", 15, 0, 15, 0,  0, 0, 15, 15, 9, 0, 0);
    frame("fhold",  6, 2, 8, 4,   2, 4, 6, 8,   9, 1, 1);

    // abandon a frame on the 4th SORT cycle
    load4(8, 6, 4, 2);
    step(); step(); step();
    chk("mid_sort_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_in_ready",  in_ready,  1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy",      busy,      0);
    got.delete();
    repeat (20) step();
    chk("abort_no_output", got.size(), 0);
`ifdef SORT_EARLY_EXIT_EN
    frame("f2143",  2, 1, 4, 3,   1, 2, 3, 4,   6, 0, 0);
`else
    frame("f2143",  2, 1, 4, 3,   1, 2, 3, 4,   9, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end
endmodule
